ram_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between two requesters: m0 (instruction fetch, read-only) and m1 (load/store, read/write).
- Arbitrates round-robin, drives the RAM's addr/data_in/read_enable/write_enable, and routes the registered RAM data_out back to the requester that issued the read.
- Range-checks every address against DEPTH and completes out-of-range requests with an error, without touching the RAM.
- Sits between the core's fetch/LSU stages and the ram instance.

---
 rtl/ram_arbiter_if.sv | 46 ++++
 rtl/ram_arbiter.sv | 91 +++++++++
 tb/tb_ram_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bundles the two requester ports and the RAM port of ram_arbiter.
// slave = arbiter side, master = requesters plus RAM (the surrounding logic).
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic                  m0_req_valid;
  logic                  m0_req_ready;
  logic [ADDR_WIDTH-1:0] m0_req_addr;
  logic                  m0_rsp_valid;
  logic [DATA_WIDTH-1:0] m0_rsp_rdata;
  logic                  m0_rsp_err;

  logic                  m1_req_valid;
  logic                  m1_req_ready;
  logic                  m1_req_we;
  logic [ADDR_WIDTH-1:0] m1_req_addr;
  logic [DATA_WIDTH-1:0] m1_req_wdata;
  logic                  m1_rsp_valid;
  logic [DATA_WIDTH-1:0] m1_rsp_rdata;
  logic                  m1_rsp_err;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_re;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  m0_req_valid, m0_req_addr,
    output m0_req_ready, m0_rsp_valid, m0_rsp_rdata, m0_rsp_err,
    input  m1_req_valid, m1_req_we, m1_req_addr, m1_req_wdata,
    output m1_req_ready, m1_rsp_valid, m1_rsp_rdata, m1_rsp_err,
    output ram_addr, ram_wdata, ram_re, ram_we,
    input  ram_rdata
  );

  modport master (
    output m0_req_valid, m0_req_addr,
    input  m0_req_ready, m0_rsp_valid, m0_rsp_rdata, m0_rsp_err,
    output m1_req_valid, m1_req_we, m1_req_addr, m1_req_wdata,
    input  m1_req_ready, m1_rsp_valid, m1_rsp_rdata, m1_rsp_err,
    input  ram_addr, ram_wdata, ram_re, ram_we,
    output ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin share of one single-port sync RAM between fetch (m0, read-only)
// and load/store (m1). One accept per cycle, fixed 1-cycle response latency.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic           clk,
  input  logic           rst,
  ram_arbiter_if.slave   bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic last_grant_q, last_grant_d;
  logic rsp_pend_q,   rsp_pend_d;
  logic rsp_owner_q,  rsp_owner_d;
  logic rsp_is_rd_q,  rsp_is_rd_d;
  logic rsp_err_q,    rsp_err_d;

  logic                  gnt_vld, gnt_id, sel_we, sel_in;
  logic [ADDR_WIDTH-1:0] sel_addr;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (!rst) begin
      if (bus.m0_req_valid && bus.m1_req_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant_q;
      end else if (bus.m0_req_valid) begin
        gnt_vld = 1'b1;
      end else if (bus.m1_req_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
    sel_addr = gnt_id ? bus.m1_req_addr : bus.m0_req_addr;
    sel_we   = gnt_id & bus.m1_req_we;
    // Unsigned compare one bit wider so DEPTH == 2^ADDR_WIDTH never flags.
    sel_in   = ({1'b0, sel_addr} < DEPTH_W);

    bus.m0_req_ready = gnt_vld & ~gnt_id;
    bus.m1_req_ready = gnt_vld &  gnt_id;
    bus.ram_addr     = gnt_vld ? sel_addr : '0;
    bus.ram_re       = gnt_vld & sel_in & ~sel_we;
    bus.ram_we       = gnt_vld & sel_in &  sel_we;
    bus.ram_wdata    = bus.ram_we ? bus.m1_req_wdata : '0;

    last_grant_d = last_grant_q;
    rsp_pend_d   = 1'b0;
    rsp_owner_d  = rsp_owner_q;
    rsp_is_rd_d  = rsp_is_rd_q;
    rsp_err_d    = rsp_err_q;
    if (gnt_vld) begin
      last_grant_d = gnt_id;
      rsp_pend_d   = 1'b1;
      rsp_owner_d  = gnt_id;
      rsp_is_rd_d  = ~sel_we & sel_in;
      rsp_err_d    = ~sel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      rsp_pend_q   <= 1'b0;
      rsp_owner_q  <= 1'b0;
      rsp_is_rd_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_pend_q   <= rsp_pend_d;
      rsp_owner_q  <= rsp_owner_d;
      rsp_is_rd_q  <= rsp_is_rd_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // A pending response is squashed as soon as rst rises, not one cycle later.
  logic rsp_live;
  assign rsp_live = rsp_pend_q & ~rst;

  always_comb begin
    bus.m0_rsp_valid = rsp_live & ~rsp_owner_q;
    bus.m1_rsp_valid = rsp_live &  rsp_owner_q;
    bus.m0_rsp_rdata = (bus.m0_rsp_valid && rsp_is_rd_q) ? bus.ram_rdata : '0;
    bus.m1_rsp_rdata = (bus.m1_rsp_valid && rsp_is_rd_q) ? bus.ram_rdata : '0;
    bus.m0_rsp_err   = bus.m0_rsp_valid & rsp_err_q;
    bus.m1_rsp_err   = bus.m1_rsp_valid & rsp_err_q;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural sync RAM; responses are
// checked by a queue-based scoreboard independent of the stimulus thread.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus ();

  ram_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:31];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct {
    logic       owner;
    logic [7:0] rdata;
    logic       err;
    int         at;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per observed response.
  always @(negedge clk) begin
    exp_t e;
    if (bus.m0_rsp_valid || bus.m1_rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {bus.m1_rsp_valid, bus.m0_rsp_valid}, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_latency", cyc, e.at + 1);
        chk("rsp_valid", {bus.m1_rsp_valid, bus.m0_rsp_valid}, e.owner ? 2'b10 : 2'b01);
        chk("rsp_rdata", e.owner ? bus.m1_rsp_rdata : bus.m0_rsp_rdata, e.rdata);
        chk("rsp_err",   e.owner ? bus.m1_rsp_err   : bus.m0_rsp_err,   e.err);
      end
    end else if (sb.size() != 0 && sb[0].at < cyc) begin
      e = sb.pop_front();
      chk("missing_rsp", {bus.m1_rsp_valid, bus.m0_rsp_valid}, e.owner ? 2'b10 : 2'b01);
    end
  end

  // ctl = {m0_ready, m1_ready, ram_re, ram_we}
  task automatic step(
    input logic v0, input logic [4:0] a0,
    input logic v1, input logic we1, input logic [4:0] a1, input logic [7:0] wd1,
    input logic [3:0] ctl, input logic chk_addr, input logic [4:0] e_addr, input logic [7:0] e_wd,
    input logic push, input logic e_own, input logic [7:0] e_rd, input logic e_err);
    bus.m0_req_valid = v0;  bus.m0_req_addr  = a0;
    bus.m1_req_valid = v1;  bus.m1_req_we    = we1;
    bus.m1_req_addr  = a1;  bus.m1_req_wdata = wd1;
    @(negedge clk);
    chk("m0_ready", bus.m0_req_ready, ctl[3]);
    chk("m1_ready", bus.m1_req_ready, ctl[2]);
    chk("ram_re",   bus.ram_re,       ctl[1]);
    chk("ram_we",   bus.ram_we,       ctl[0]);
    if (chk_addr) begin
      chk("ram_addr",  bus.ram_addr,  e_addr);
      chk("ram_wdata", bus.ram_wdata, e_wd);
    end
    if (push) sb.push_back('{e_own, e_rd, e_err, cyc});
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h10 + 8'(i);
    bus.ram_rdata = '0;
    rst = 1'b1;
    bus.m0_req_valid = 0; bus.m0_req_addr = 0;
    bus.m1_req_valid = 0; bus.m1_req_we = 0; bus.m1_req_addr = 0; bus.m1_req_wdata = 0;
    @(posedge clk); #1;
    // Reset: idle, then with both valids raised; nothing may be granted.
    step(0,0, 0,0,0,0,     4'b0000, 1,0,0,     0,0,0,0);
    step(1,1, 1,1,2,8'h55, 4'b0000, 1,0,0,     0,0,0,0);
    rst = 1'b0;
    // First cycle after reset: all response outputs quiet.
    bus.m0_req_valid = 0; bus.m1_req_valid = 0;
    @(negedge clk);
    chk("post_rst_rsp", {bus.m0_rsp_valid, bus.m0_rsp_rdata, bus.m0_rsp_err,
                         bus.m1_rsp_valid, bus.m1_rsp_rdata, bus.m1_rsp_err}, 0);
    @(posedge clk); #1;

    // Write A5 @3 then fetch @3.
    step(0,0, 1,1,3,8'hA5, 4'b0101, 1,3,8'hA5, 1,1,8'h00,0);
    step(1,3, 0,0,0,0,     4'b1010, 1,3,8'h00, 1,0,8'hA5,0);
    step(0,0, 1,0,3,0,     4'b0110, 1,3,8'h00, 1,1,8'hA5,0);
    // Contention: m0 @1, m1 @2, alternate starting with m0.
    step(1,1, 1,0,2,0,     4'b1010, 1,1,8'h00, 1,0,8'h11,0);
    step(1,1, 1,0,2,0,     4'b0110, 1,2,8'h00, 1,1,8'h12,0);
    step(1,1, 1,0,2,0,     4'b1010, 1,1,8'h00, 1,0,8'h11,0);
    step(1,1, 1,0,2,0,     4'b0110, 1,2,8'h00, 1,1,8'h12,0);
    // Out of range m1 read @20: RAM untouched, error response.
    step(0,0, 1,0,20,0,    4'b0100, 0,0,0,     1,1,8'h00,1);
    // Back-to-back write/read of @7.
    step(0,0, 1,1,7,8'h3C, 4'b0101, 1,7,8'h3C, 1,1,8'h00,0);
    step(0,0, 1,0,7,0,     4'b0110, 1,7,8'h00, 1,1,8'h3C,0);
    step(0,0, 0,0,0,0,     4'b0000, 0,0,0,     0,0,0,0);
    // Boundaries: @16 is first illegal, @15 last legal.
    step(1,16, 0,0,0,0,    4'b1000, 0,0,0,     1,0,8'h00,1);
    step(0,0, 1,0,15,0,    4'b0110, 1,15,8'h00, 1,1,8'h1F,0);
    // Out-of-range write from m1: no ram_we, error ack.
    step(0,0, 1,1,31,8'h77, 4'b0100, 0,0,0,    1,1,8'h00,1);
    // m0 read accepted, then rst: its response must be dropped.
    step(1,5, 0,0,0,0,     4'b1010, 1,5,8'h00, 0,0,0,0);
    rst = 1'b1;
    step(0,0, 0,0,0,0,     4'b0000, 1,0,0,     0,0,0,0);
    rst = 1'b0;
    // After reset m0 wins the first conflict again.
    step(1,1, 1,0,2,0,     4'b1010, 1,1,8'h00, 1,0,8'h11,0);
    step(0,0, 0,0,0,0,     4'b0000, 0,0,0,     0,0,0,0);
    step(0,0, 0,0,0,0,     4'b0000, 0,0,0,     0,0,0,0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
